// File: rtl/pong_pkg.sv
// Shared state encoding and default court geometry for the pong scoring slice.
package pong_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    PAUSE = 2'd2,
    OVER  = 2'd3
  } state_t;

  localparam int H_RES_DEF      = 640;
  localparam int WALL_WIDTH_DEF = 14;
  localparam int BALL_W_DEF     = 32;
endpackage

// File: rtl/bcd_counter2.sv
// Two-digit BCD score counter with a binary shadow for cheap win comparison.
module bcd_counter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       clr,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic [6:0] bin
);

  // 99 is a ceiling: the count holds rather than wrapping to 00.
  function automatic logic [14:0] bcd_inc_sat(input logic [3:0] t, input logic [3:0] o,
                                              input logic [6:0] b);
    if (t == 4'd9 && o == 4'd9)
      return {t, o, b};
    else if (o == 4'd9)
      return {t + 4'd1, 4'd0, b + 7'd1};
    else
      return {t, o + 4'd1, b + 7'd1};
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tens <= '0;
      ones <= '0;
      bin  <= '0;
    end else if (clr) begin
      tens <= '0;
      ones <= '0;
      bin  <= '0;
    end else if (inc) begin
      {tens, ones, bin} <= bcd_inc_sat(tens, ones, bin);
    end
  end

endmodule

// File: rtl/rally_scorer.sv
// Point/game referee: watches the ball for goal-line crossings, keeps BCD scores,
// paces re-serves and declares the winner.
module rally_scorer
  import pong_pkg::*;
#(
  parameter int H_RES       = H_RES_DEF,
  parameter int WALL_WIDTH  = WALL_WIDTH_DEF,
  parameter int BALL_W      = BALL_W_DEF,
  parameter int WIN_SCORE   = 11,
  parameter int PAUSE_TICKS = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic [9:0] ball_x,
  input  logic       start,
  output logic       ball_run,
  output logic       serve_req,
  output logic       serve_dir,
  output logic       point_pulse,
  output logic       game_over,
  output logic       winner,
  output logic [3:0] score_left_tens,
  output logic [3:0] score_left_ones,
  output logic [3:0] score_right_tens,
  output logic [3:0] score_right_ones
);

  localparam int PW = (PAUSE_TICKS > 1) ? $clog2(PAUSE_TICKS) : 1;

  state_t        state, state_d;
  logic [PW-1:0] pause_cnt, cnt_d;
  logic          dir_d, win_d, sreq_d, pp_d;
  logic          inc_l, inc_r, clr;
  logic [6:0]    bin_l, bin_r;
  logic          l_out, r_out, left_win, right_win;
  logic [10:0]   r_edge;

  // Right edge of the ball at 11 bits so x near 1023 cannot wrap into the court.
  assign r_edge    = {1'b0, ball_x} + 11'(BALL_W);
  assign l_out     = ({1'b0, ball_x} <= 11'(WALL_WIDTH));
  assign r_out     = (r_edge >= 11'(H_RES - WALL_WIDTH));
  assign left_win  = (({1'b0, bin_l} + 8'd1) == 8'(WIN_SCORE));
  assign right_win = (({1'b0, bin_r} + 8'd1) == 8'(WIN_SCORE));

  always_comb begin
    state_d = state;
    cnt_d   = pause_cnt;
    dir_d   = serve_dir;
    win_d   = winner;
    sreq_d  = 1'b0;
    pp_d    = 1'b0;
    inc_l   = 1'b0;
    inc_r   = 1'b0;
    clr     = 1'b0;
    if (frame_tick) begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state_d = PLAY;
            sreq_d  = 1'b1;
          end
        end
        PLAY: begin
          if (l_out) begin
            inc_r   = 1'b1;
            dir_d   = 1'b0;
            pp_d    = 1'b1;
            cnt_d   = PW'(PAUSE_TICKS - 1);
            state_d = right_win ? OVER : PAUSE;
            if (right_win) win_d = 1'b0;
          end else if (r_out) begin
            inc_l   = 1'b1;
            dir_d   = 1'b1;
            pp_d    = 1'b1;
            cnt_d   = PW'(PAUSE_TICKS - 1);
            state_d = left_win ? OVER : PAUSE;
            if (left_win) win_d = 1'b1;
          end
        end
        PAUSE: begin
          if (pause_cnt == '0) begin
            state_d = PLAY;
            sreq_d  = 1'b1;
          end else begin
            cnt_d = pause_cnt - PW'(1);
          end
        end
        OVER: begin
          if (start) begin
            clr     = 1'b1;
            sreq_d  = 1'b1;
            state_d = PLAY;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      pause_cnt   <= '0;
      ball_run    <= 1'b0;
      serve_req   <= 1'b0;
      serve_dir   <= 1'b1;
      point_pulse <= 1'b0;
      game_over   <= 1'b0;
      winner      <= 1'b0;
    end else begin
      state       <= state_d;
      pause_cnt   <= cnt_d;
      ball_run    <= (state_d == PLAY);
      serve_req   <= sreq_d;
      serve_dir   <= dir_d;
      point_pulse <= pp_d;
      game_over   <= (state_d == OVER);
      winner      <= win_d;
    end
  end

  bcd_counter2 u_left (
    .clk   (clk),
    .reset (reset),
    .inc   (inc_l),
    .clr   (clr),
    .tens  (score_left_tens),
    .ones  (score_left_ones),
    .bin   (bin_l)
  );

  bcd_counter2 u_right (
    .clk   (clk),
    .reset (reset),
    .inc   (inc_r),
    .clr   (clr),
    .tens  (score_right_tens),
    .ones  (score_right_ones),
    .bin   (bin_r)
  );

endmodule

// File: tb/tb_rally_scorer.sv
// Scoreboard bench for rally_scorer: directed rallies push expected pulse events,
// a monitor pops and compares on every serve_req/point_pulse.
module tb_rally_scorer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic [9:0] ball_x = 10'd300;
  logic       start = 1'b0;
  logic       ball_run, serve_req, serve_dir, point_pulse, game_over, winner;
  logic [3:0] score_left_tens, score_left_ones, score_right_tens, score_right_ones;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    bit         pp;
    bit         sr;
    bit         run;
    bit         dir;
    bit         go;
    bit         win;
    logic [7:0] l;
    logic [7:0] r;
  } ev_t;

  ev_t q[$];

  rally_scorer #(
    .H_RES(640), .WALL_WIDTH(14), .BALL_W(32), .WIN_SCORE(11), .PAUSE_TICKS(50)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .frame_tick       (frame_tick),
    .ball_x           (ball_x),
    .start            (start),
    .ball_run         (ball_run),
    .serve_req        (serve_req),
    .serve_dir        (serve_dir),
    .point_pulse      (point_pulse),
    .game_over        (game_over),
    .winner           (winner),
    .score_left_tens  (score_left_tens),
    .score_left_ones  (score_left_ones),
    .score_right_tens (score_right_tens),
    .score_right_ones (score_right_ones)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic logic [7:0] bcd(input int k);
    return {4'(k / 10), 4'(k % 10)};
  endfunction

  task automatic expect_ev(input bit pp, input bit sr, input bit run, input bit dir,
                           input bit go, input bit win, input logic [7:0] l, input logic [7:0] r);
    ev_t e;
    e.pp = pp; e.sr = sr; e.run = run; e.dir = dir; e.go = go; e.win = win; e.l = l; e.r = r;
    q.push_back(e);
  endtask

  task automatic tick();
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic serve_after(input int n, input bit dir, input logic [7:0] l, input logic [7:0] r);
    repeat (n) tick();
    expect_ev(1'b0, 1'b1, 1'b1, dir, 1'b0, 1'b0, l, r);
    tick();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ball_run"}, ball_run, 0);
    chk({tag, "_serve_req"}, serve_req, 0);
    chk({tag, "_point_pulse"}, point_pulse, 0);
    chk({tag, "_game_over"}, game_over, 0);
    chk({tag, "_winner"}, winner, 0);
    chk({tag, "_serve_dir"}, serve_dir, 1);
    chk({tag, "_scores"}, {score_left_tens, score_left_ones, score_right_tens, score_right_ones}, 0);
  endtask

  always @(negedge clk) begin
    if (!reset && (point_pulse || serve_req)) begin
      if (q.size() == 0) begin
        chk("unexpected_pulse", {30'd0, point_pulse, serve_req}, 0);
      end else begin
        ev_t e;
        e = q.pop_front();
        chk("ev_point_pulse", point_pulse, e.pp);
        chk("ev_serve_req", serve_req, e.sr);
        chk("ev_ball_run", ball_run, e.run);
        chk("ev_serve_dir", serve_dir, e.dir);
        chk("ev_game_over", game_over, e.go);
        if (e.go) chk("ev_winner", winner, e.win);
        chk("ev_score_left", {score_left_tens, score_left_ones}, e.l);
        chk("ev_score_right", {score_right_tens, score_right_ones}, e.r);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    start = 1'b1;
    tick();
    check_reset_vals("tick_in_reset");
    start = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // Serve from IDLE
    start = 1'b1;
    expect_ev(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    start = 1'b0;
    chk("play_ball_run", ball_run, 1);

    // Left goal: right scores, then 50-tick pause
    ball_x = 10'd10;
    expect_ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01);
    tick();
    ball_x = 10'd300;
    chk("pause_ball_run", ball_run, 0);
    serve_after(49, 1'b0, 8'h00, 8'h01);

    // Right goal-line boundary
    ball_x = 10'd593;
    tick();
    chk("r_edge_593_no_point", score_left_ones, 0);
    ball_x = 10'd594;
    expect_ev(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h01, 8'h01);
    tick();
    ball_x = 10'd300;
    serve_after(49, 1'b1, 8'h01, 8'h01);

    // Left runs to 11 through the 09->10 carry
    for (int k = 2; k <= 11; k++) begin
      ball_x = 10'd594;
      expect_ev(1'b1, 1'b0, 1'b0, 1'b1, k == 11, k == 11, bcd(k), 8'h01);
      tick();
      ball_x = 10'd300;
      if (k == 10) chk("carry_left_10", {score_left_tens, score_left_ones}, 8'h10);
      if (k < 11) serve_after(49, 1'b1, bcd(k), 8'h01);
    end
    chk("over_game_over", game_over, 1);
    chk("over_winner", winner, 1);
    chk("over_ball_run", ball_run, 0);
    ball_x = 10'd600;
    repeat (3) tick();
    ball_x = 10'd300;
    start = 1'b1;
    expect_ev(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    start = 1'b0;
    chk("new_game_over_clear", game_over, 0);

    // Ball parked in left zone: one point only, start ignored in pause
    ball_x = 10'd5;
    expect_ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01);
    repeat (3) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("pause_start_ignored", ball_run, 0);
    ball_x = 10'd300;
    serve_after(46, 1'b0, 8'h00, 8'h01);

    // Right to 07, then reset mid-pause
    for (int k = 2; k <= 7; k++) begin
      ball_x = 10'd10;
      expect_ev(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, bcd(k));
      tick();
      ball_x = 10'd300;
      if (k < 7) serve_after(49, 1'b0, 8'h00, bcd(k));
    end
    chk("pre_reset_right", {score_right_tens, score_right_ones}, 8'h07);
    repeat (20) tick();
    #2 reset = 1'b1;
    #1 check_reset_vals("async_reset");
    start = 1'b1;
    repeat (2) tick();
    check_reset_vals("ticks_in_reset");
    start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk("idle_no_start", ball_run, 0);
    start = 1'b1;
    expect_ev(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    start = 1'b0;

    repeat (2) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
